// File: rtl/stack_arbiter_if.sv
// stack_arbiter_if: requester handshakes, stack strobes and status of the stack arbiter
// master: requesters + stack side (drives req/op/wdata and stack flags/read data)
// slave : arbiter side (drives ack/err/rdata, stack strobes and status)
interface stack_arbiter_if #(
  parameter int WIDTH_DATA = 16,
  parameter int LEVEL_W = 10
);
  logic req0, op0, ack0, err0;
  logic req1, op1, ack1, err1;
  logic [WIDTH_DATA-1:0] wdata0, wdata1, rdata;
  logic stk_push, stk_pop, stk_full, stk_empty;
  logic [WIDTH_DATA-1:0] stk_data_in, stk_data_out;
  logic busy, grant_id;
  logic [LEVEL_W-1:0] level;
  modport master (
    output req0, op0, wdata0, req1, op1, wdata1, stk_data_out, stk_full, stk_empty,
    input  ack0, err0, ack1, err1, rdata, stk_push, stk_pop, stk_data_in, busy, grant_id, level
  );
  modport slave (
    input  req0, op0, wdata0, req1, op1, wdata1, stk_data_out, stk_full, stk_empty,
    output ack0, err0, ack1, err1, rdata, stk_push, stk_pop, stk_data_in, busy, grant_id, level
  );
endinterface

// File: rtl/stack_arbiter.sv
// stack_arbiter: shares a single-port stack between CALL/RET (req0) and interrupt (req1) requesters
// Ports: clk, reset (async active-low), bus (stack_arbiter_if.slave: req/ack handshakes,
//   stack strobes/flags/data, busy, grant_id, level). All outputs are registered.
// Build option: STACK_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed req1-first priority.
module stack_arbiter #(
  parameter int WIDTH_DATA = 16,
  parameter int LEVEL_W = 10,
  parameter int DEPTH = 10
) (
  input logic clk,
  input logic reset,
  stack_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic op_q, op_d, grant_id_q, grant_id_d, busy_q, busy_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d, err0_q, err0_d, err1_q, err1_d;
  logic stk_push_q, stk_push_d, stk_pop_q, stk_pop_d;
  logic [WIDTH_DATA-1:0] stk_data_in_q, stk_data_in_d, rdata_q, rdata_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic req_any, pick, pick_op, rej;
  logic [WIDTH_DATA-1:0] pick_wd;
`ifdef STACK_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign pick = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  // every grant, error grants included, moves the round-robin pointer
  assign last_d = (state_q == IDLE && req_any) ? pick : last_q;
`else
  assign pick = bus.req1;
`endif
  assign req_any = bus.req0 | bus.req1;
  assign pick_op = pick ? bus.op1 : bus.op0;
  assign pick_wd = pick ? bus.wdata1 : bus.wdata0;
  // level guards as well as the stack flags keep level inside 0..DEPTH
  assign rej = pick_op ? (bus.stk_full || level_q == LEVEL_W'(DEPTH))
                       : (bus.stk_empty || level_q == '0);
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    grant_id_d = grant_id_q;
    stk_data_in_d = stk_data_in_q;
    rdata_d = rdata_q;
    level_d = level_q;
    stk_push_d = 1'b0;
    stk_pop_d = 1'b0;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    err0_d = 1'b0;
    err1_d = 1'b0;
    case (state_q)
      IDLE: if (req_any) begin
        state_d = rej ? RESP : ISSUE;
        grant_id_d = pick;
        op_d = pick_op;
        stk_data_in_d = pick_wd;
        stk_push_d = !rej && pick_op;
        stk_pop_d = !rej && !pick_op;
        ack0_d = rej && !pick;
        ack1_d = rej && pick;
        err0_d = rej && !pick;
        err1_d = rej && pick;
      end
      ISSUE: begin
        state_d = WAIT;
        level_d = op_q ? level_q + 1'b1 : level_q - 1'b1;
      end
      WAIT: begin
        state_d = RESP;
        rdata_d = op_q ? rdata_q : bus.stk_data_out;
        ack0_d = !grant_id_q;
        ack1_d = grant_id_q;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q <= 1'b0;
      grant_id_q <= 1'b0;
      busy_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      stk_push_q <= 1'b0;
      stk_pop_q <= 1'b0;
      stk_data_in_q <= '0;
      rdata_q <= '0;
      level_q <= '0;
`ifdef STACK_ARB_ROUND_ROBIN_EN
      last_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      grant_id_q <= grant_id_d;
      busy_q <= busy_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      err0_q <= err0_d;
      err1_q <= err1_d;
      stk_push_q <= stk_push_d;
      stk_pop_q <= stk_pop_d;
      stk_data_in_q <= stk_data_in_d;
      rdata_q <= rdata_d;
      level_q <= level_d;
`ifdef STACK_ARB_ROUND_ROBIN_EN
      last_q <= last_d;
`endif
    end
  end
  assign bus.ack0 = ack0_q;
  assign bus.ack1 = ack1_q;
  assign bus.err0 = err0_q;
  assign bus.err1 = err1_q;
  assign bus.rdata = rdata_q;
  assign bus.stk_push = stk_push_q;
  assign bus.stk_pop = stk_pop_q;
  assign bus.stk_data_in = stk_data_in_q;
  assign bus.busy = busy_q;
  assign bus.grant_id = grant_id_q;
  assign bus.level = level_q;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: table-driven + scoreboard bench for stack_arbiter with a behavioural 10-entry stack
module tb_stack_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  stack_arbiter_if #(.WIDTH_DATA(16), .LEVEL_W(10)) bus ();
  stack_arbiter #(.WIDTH_DATA(16), .LEVEL_W(10), .DEPTH(10)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  logic [15:0] mem [0:9];
  int sp;
  always @(posedge clk or negedge reset)
    if (!reset) begin
      sp <= 0;
      bus.stk_data_out <= '0;
    end else if (bus.stk_push && sp < 10) begin
      mem[sp] <= bus.stk_data_in;
      sp <= sp + 1;
    end else if (bus.stk_pop && sp > 0) begin
      bus.stk_data_out <= mem[sp-1];
      sp <= sp - 1;
    end
  assign bus.stk_full = (sp == 10);
  assign bus.stk_empty = (sp == 0);
  int both_hi = 0;
  always @(negedge clk) if (bus.stk_push && bus.stk_pop) both_hi <= both_hi + 1;
  typedef struct {
    bit id;
    bit op;
    logic [15:0] wd;
    bit err;
    logic [15:0] rd;
    logic [9:0] lev;
    int lat;
  } vec_t;
  vec_t sb[$];
  vec_t tv[$];
  int checks = 0;
  int errors = 0;
  bit tb_last = 1'b1;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction
  function automatic vec_t mk(bit id, bit op, logic [15:0] wd, bit err, logic [15:0] rd, int lev, int lat);
    vec_t v;
    v.id = id;
    v.op = op;
    v.wd = wd;
    v.err = err;
    v.rd = rd;
    v.lev = 10'(lev);
    v.lat = lat;
    return v;
  endfunction
  task automatic drive(input bit id, input bit op, input logic [15:0] wd);
    if (id) begin
      bus.req1 = 1'b1;
      bus.op1 = op;
      bus.wdata1 = wd;
    end else begin
      bus.req0 = 1'b1;
      bus.op0 = op;
      bus.wdata0 = wd;
    end
  endtask
  task automatic collect(input bit keep, output int idle);
    int lat, np, npo;
    logic [15:0] din;
    vec_t e;
    lat = 0;
    np = 0;
    npo = 0;
    idle = 0;
    din = '0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.stk_push) begin
        np++;
        din = bus.stk_data_in;
      end
      if (bus.stk_pop) npo++;
      if (!bus.busy) idle++;
    end while (!(bus.ack0 || bus.ack1) && lat < 20);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: ack with no pending transaction");
      return;
    end
    e = sb.pop_front();
    if (!keep) begin
      if (e.id) bus.req1 = 1'b0;
      else bus.req0 = 1'b0;
    end
    chk("ack_id", {bus.ack1, bus.ack0}, e.id ? 2 : 1);
    chk("err", {bus.err1, bus.err0}, e.err ? (e.id ? 2 : 1) : 0);
    chk("level", bus.level, e.lev);
    chk("grant_id", bus.grant_id, e.id);
    chk("latency", lat, e.lat);
    chk("push_cnt", np, e.op && !e.err);
    chk("pop_cnt", npo, !e.op && !e.err);
    if (e.op && !e.err) chk("push_data", din, e.wd);
    if (!e.op) chk("rdata", bus.rdata, e.rd);
    tb_last = e.id;
  endtask
  task automatic run(input vec_t v);
    int idle;
    @(posedge clk);
    #1;
    v.lat = v.err ? 1 : 3;
    sb.push_back(v);
    drive(v.id, v.op, v.wd);
    collect(1'b0, idle);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int idle, n, lev;
    bit w;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.op0 = 1'b0;
    bus.op1 = 1'b0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.stk_push, bus.stk_pop, bus.busy, bus.grant_id}, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_data", {bus.rdata, bus.stk_data_in}, 0);
    reset = 1'b1;
    tv.push_back(mk(0, 1, 16'h1234, 0, 16'h0000, 1, 0));
    tv.push_back(mk(0, 0, 16'h0000, 0, 16'h1234, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 1, 16'h1234, 0, 0));
    for (int i = 0; i < 10; i++) tv.push_back(mk(i[0], 1, 16'hA000 + 16'(i), 0, 16'h0000, i + 1, 0));
    tv.push_back(mk(1, 1, 16'hBEEF, 1, 16'h0000, 10, 0));
    tv.push_back(mk(0, 1, 16'hBEEF, 1, 16'h0000, 10, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 16'hA009, 9, 0));
    foreach (tv[k]) run(tv[k]);
    @(posedge clk);
    #1;
    drive(0, 1, 16'h7777);
    n = 0;
    while (!bus.stk_push && n < 5) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("issue_reached", bus.stk_push, 1);
    reset = 1'b0;
    #1;
    chk("rst_async_push", bus.stk_push, 0);
    chk("rst_async_busy", bus.busy, 0);
    chk("rst_async_level", bus.level, 0);
    bus.req0 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tb_last = 1'b1;
    n = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      n += int'(bus.ack0 | bus.ack1);
    end
    chk("no_ack_after_rst", n, 0);
    lev = 0;
    for (int r = 0; r < 4; r++) begin
      @(posedge clk);
      #1;
`ifdef STACK_ARB_ROUND_ROBIN_EN
      w = ~tb_last;
`else
      w = 1'b1;
`endif
      lev++;
      sb.push_back(mk(w, 1, w ? 16'h5555 : 16'hAAAA, 0, 16'h0000, lev, 3));
      lev++;
      sb.push_back(mk(~w, 1, w ? 16'hAAAA : 16'h5555, 0, 16'h0000, lev, 4));
      drive(0, 1, 16'hAAAA);
      drive(1, 1, 16'h5555);
      collect(1'b0, idle);
      collect(1'b0, idle);
    end
    @(posedge clk);
    #1;
    sb.push_back(mk(0, 1, 16'hC0DE, 0, 16'h0000, 9, 3));
    sb.push_back(mk(0, 1, 16'hC0DE, 0, 16'h0000, 10, 4));
    drive(0, 1, 16'hC0DE);
    collect(1'b1, idle);
    collect(1'b0, idle);
    chk("b2b_idle_cycles", idle, 1);
    chk("push_pop_overlap", both_hi, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
